// File: rtl/hps_fpga_fifo_write_if.sv
// Avalon-MM slave bus plus fabric sample stream for the HPS capture FIFO.
interface hps_fpga_fifo_write_if #(
  parameter int unsigned DATA_W = 16
);
  logic [1:0]        address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              irq;

  modport slave (
    input  address, chipselect, read_n, write_n, writedata, sample_data, sample_valid,
    output readdata, sample_ready, irq
  );

  modport master (
    output address, chipselect, read_n, write_n, writedata, sample_data, sample_valid,
    input  readdata, sample_ready, irq
  );
endinterface

// File: rtl/hps_fpga_fifo_write.sv
// Fabric-to-HPS sample FIFO behind an Avalon-MM slave: fabric pushes samples,
// the HPS pops them through the DATA register and watches level/irq.
module hps_fpga_fifo_write #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hps_fpga_fifo_write_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_CONTROL = 2'd2;
  localparam logic [1:0] A_CLEAR   = 2'd3;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_ptr_nx, wr_ptr, wr_ptr_nx;
  logic [LVL_W-1:0]      level, level_nx;
  logic                  enable, enable_nx, irq_en, irq_en_nx;
  logic [15:0]           threshold, threshold_nx;
  logic                  overflow, overflow_nx, underflow, underflow_nx;
  logic [31:0]           readdata_q, readdata_nx;
  logic                  irq_q, irq_nx, ready_q, ready_nx;

  logic rd, wr, empty, full, pop_req, pop, push, drop, flush, clr_wr;
  logic unused_wd;

  assign rd      = bus.chipselect & ~bus.read_n;
  assign wr      = bus.chipselect & ~bus.write_n;
  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop_req = rd & (bus.address == A_DATA);
  assign pop     = pop_req & ~empty;
  // Push is judged on the pre-pop full flag, so a pop never makes room for a same-cycle push.
  assign push    = enable & bus.sample_valid & ~full;
  assign drop    = enable & bus.sample_valid & full;
  assign flush   = wr & (bus.address == A_CONTROL) & bus.writedata[2];
  assign clr_wr  = wr & (bus.address == A_CLEAR);

  assign unused_wd = ^bus.writedata[15:4];

  assign bus.readdata     = readdata_q;
  assign bus.irq          = irq_q;
  assign bus.sample_ready = ready_q;

  // Next-state for pointers, flags, control and registered outputs.
  always_comb begin
    rd_ptr_nx    = rd_ptr;
    wr_ptr_nx    = wr_ptr;
    level_nx     = level;
    enable_nx    = enable;
    irq_en_nx    = irq_en;
    threshold_nx = threshold;
    readdata_nx  = readdata_q;

    if (rd) begin
      case (bus.address)
        A_DATA:    readdata_nx = empty ? '0 : 32'(mem[rd_ptr]);
        A_STATUS:  readdata_nx = {16'(level), 11'd0, irq_q, underflow, overflow, full, empty};
        A_CONTROL: readdata_nx = {threshold, 14'd0, irq_en, enable};
        default:   readdata_nx = '0;
      endcase
    end

    // Flush wins over any same-cycle push or pop; the read above still sees the old head.
    if (flush) begin
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
      level_nx  = '0;
    end else begin
      if (push) wr_ptr_nx = wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_nx = rd_ptr + DEPTH_LOG2'(1);
      level_nx = level + LVL_W'(push) - LVL_W'(pop);
    end

    if (wr && (bus.address == A_CONTROL)) begin
      enable_nx    = bus.writedata[0];
      irq_en_nx    = bus.writedata[1];
      threshold_nx = bus.writedata[31:16];
    end

    // Set events beat a same-cycle clear.
    overflow_nx  = drop | (overflow & ~(clr_wr & bus.writedata[2]));
    underflow_nx = (pop_req & empty) | (underflow & ~(clr_wr & bus.writedata[3]));

    irq_nx   = irq_en & (((threshold != '0) && (32'(level) >= 32'(threshold))) | overflow);
    ready_nx = enable_nx & (level_nx != LVL_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      threshold  <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nx;
      wr_ptr     <= wr_ptr_nx;
      level      <= level_nx;
      enable     <= enable_nx;
      irq_en     <= irq_en_nx;
      threshold  <= threshold_nx;
      overflow   <= overflow_nx;
      underflow  <= underflow_nx;
      readdata_q <= readdata_nx;
      irq_q      <= irq_nx;
      ready_q    <= ready_nx;
    end
  end

  // Sample storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= bus.sample_data;
  end

endmodule

// File: tb/tb_hps_fpga_fifo_write.sv
// Scoreboard bench for hps_fpga_fifo_write: a queue-based reference model predicts
// every read response plus irq/sample_ready; a monitor compares against the DUT.
module tb_hps_fpga_fifo_write;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hps_fpga_fifo_write_if #(.DATA_W(16)) bus ();

  hps_fpga_fifo_write #(.DATA_W(16), .DEPTH_LOG2(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, flags and control are plain variables.
  logic [15:0] m_q [$];
  logic [31:0] exp_q [$];
  bit          m_en, m_ien, m_ovf, m_unf, m_irq, m_rdy;
  int          m_thr, m_lvl;
  bit          m_rd, m_wr, m_sv, m_irq_nx, m_ovf_set, m_unf_set;
  logic [1:0]  m_addr;
  logic [31:0] m_wd, m_resp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      exp_q.delete();
      m_en = 0; m_ien = 0; m_ovf = 0; m_unf = 0; m_irq = 0; m_rdy = 0; m_thr = 0;
    end else begin
      m_rd   = bus.chipselect && !bus.read_n;
      m_wr   = bus.chipselect && !bus.write_n;
      m_addr = bus.address;
      m_wd   = bus.writedata;
      m_sv   = bus.sample_valid;
      m_lvl  = m_q.size();
      m_irq_nx = m_ien && ((m_thr != 0 && m_lvl >= m_thr) || m_ovf);
      if (m_rd) begin
        case (m_addr)
          2'd0: m_resp = (m_lvl == 0) ? 32'd0 : {16'd0, m_q[0]};
          2'd1: m_resp = (m_lvl << 16) | (32'(m_irq) << 4) | (32'(m_unf) << 3) |
                         (32'(m_ovf) << 2) | (32'(m_lvl == DEPTH) << 1) | 32'(m_lvl == 0);
          2'd2: m_resp = (m_thr << 16) | (32'(m_ien) << 1) | 32'(m_en);
          default: m_resp = 32'd0;
        endcase
        exp_q.push_back(m_resp);
      end
      m_ovf_set = m_en && m_sv && (m_lvl == DEPTH);
      m_unf_set = m_rd && m_addr == 2'd0 && m_lvl == 0;
      if (m_wr && m_addr == 2'd2 && m_wd[2]) m_q.delete();
      else begin
        if (m_rd && m_addr == 2'd0 && m_lvl > 0) void'(m_q.pop_front());
        if (m_en && m_sv && m_lvl < DEPTH) m_q.push_back(bus.sample_data);
      end
      m_ovf = m_ovf_set || (m_ovf && !(m_wr && m_addr == 2'd3 && m_wd[2]));
      m_unf = m_unf_set || (m_unf && !(m_wr && m_addr == 2'd3 && m_wd[3]));
      if (m_wr && m_addr == 2'd2) begin
        m_en  = m_wd[0];
        m_ien = m_wd[1];
        m_thr = int'(m_wd[31:16]);
      end
      m_irq = m_irq_nx;
      m_rdy = m_en && (m_q.size() < DEPTH);
    end
  end

  // Monitor: a read sampled at an edge yields readdata just after it.
  bit          mon_seen;
  logic [31:0] mon_exp;
  always @(posedge clk) begin
    mon_seen = reset_n && bus.chipselect && !bus.read_n;
    #1;
    if (reset_n) begin
      if (mon_seen) begin
        if (exp_q.size() == 0) check("sb_underrun", 32'd1, 32'd0);
        else begin
          mon_exp = exp_q.pop_front();
          check("sb_readdata", bus.readdata, mon_exp);
        end
      end
      check("sb_irq", 32'(bus.irq), 32'(m_irq));
      check("sb_sample_ready", 32'(bus.sample_ready), 32'(m_rdy));
    end
  end

  task automatic drive(input bit rd, input bit wr, input logic [1:0] addr,
                       input logic [31:0] wd, input bit sv, input logic [15:0] sd);
    bus.chipselect   = rd | wr;
    bus.read_n       = ~rd;
    bus.write_n      = ~wr;
    bus.address      = addr;
    bus.writedata    = wd;
    bus.sample_valid = sv;
    bus.sample_data  = sd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, 32'd0, 0, 16'd0);
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] wd);
    drive(0, 1, addr, wd, 0, 16'd0);
  endtask

  task automatic push(input logic [15:0] d);
    drive(0, 0, 2'd0, 32'd0, 1, d);
  endtask

  task automatic rd_expect(input logic [1:0] addr, input logic [31:0] exp, input string name);
    drive(1, 0, addr, 32'd0, 0, 16'd0);
    check(name, bus.readdata, exp);
  endtask

  int rd_pct;
  logic [1:0] r_addr;
  logic [31:0] r_wd;
  bit r_rd, r_wr;

  initial begin
    bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1; bus.address = 0;
    bus.writedata = 0; bus.sample_valid = 0; bus.sample_data = 0;
    repeat (2) @(negedge clk);
    check("reset_readdata", bus.readdata, 32'd0);
    check("reset_irq", 32'(bus.irq), 32'd0);
    check("reset_ready", 32'(bus.sample_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    rd_expect(2'd1, 32'h0000_0001, "status_after_reset");
    rd_expect(2'd2, 32'h0000_0000, "control_after_reset");

    wr_reg(2'd2, 32'h1);
    push(16'h1234); push(16'hABCD); push(16'h0007);
    rd_expect(2'd1, 32'h0003_0000, "status_level3");
    rd_expect(2'd0, 32'h0000_1234, "data0");
    rd_expect(2'd0, 32'h0000_ABCD, "data1");
    rd_expect(2'd0, 32'h0000_0007, "data2");
    rd_expect(2'd1, 32'h0000_0001, "status_drained");

    for (int i = 0; i <= 256; i++) push(16'(i));
    check("full_ready_low", 32'(bus.sample_ready), 32'd0);
    rd_expect(2'd1, 32'h0100_0006, "status_full_ovf");
    rd_expect(2'd0, 32'h0000_0000, "data_first_of_full");
    wr_reg(2'd2, 32'h5);
    rd_expect(2'd1, 32'h0000_0005, "status_after_flush");

    rd_expect(2'd0, 32'h0000_0000, "data_empty");
    rd_expect(2'd1, 32'h0000_000D, "status_underflow");
    wr_reg(2'd3, 32'h8);
    rd_expect(2'd1, 32'h0000_0005, "status_unf_cleared");
    wr_reg(2'd3, 32'h4);

    wr_reg(2'd2, 32'h0004_0003);
    push(16'h11); push(16'h22); push(16'h33);
    idle();
    check("irq_below_thr", 32'(bus.irq), 32'd0);
    push(16'h44);
    check("irq_not_yet", 32'(bus.irq), 32'd0);
    idle();
    check("irq_at_thr", 32'(bus.irq), 32'd1);
    rd_expect(2'd0, 32'h0000_0011, "irq_pop");
    idle();
    check("irq_after_pop", 32'(bus.irq), 32'd0);

    wr_reg(2'd2, 32'h1);
    wr_reg(2'd2, 32'h5);
    for (int i = 0; i < 10; i++) push(16'(16'h100 + i));
    rd_expect(2'd1, 32'h000A_0000, "status_level10");
    drive(0, 1, 2'd2, 32'h5, 1, 16'hBEEF);
    rd_expect(2'd1, 32'h0000_0000 | 32'h1, "status_flush_push");

    // Randomized traffic in three phases of differing read pressure.
    for (int ph = 0; ph < 3; ph++) begin
      rd_pct = (ph == 0) ? 20 : (ph == 1) ? 70 : 40;
      for (int n = 0; n < 900; n++) begin
        r_rd = ($urandom_range(0, 99) < rd_pct);
        r_wr = !r_rd && ($urandom_range(0, 99) < 6);
        if (r_rd) r_addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        else r_addr = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
        if (r_addr == 2'd2)
          r_wd = {16'($urandom_range(0, 12)), 13'd0, 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
        else r_wd = $urandom;
        drive(r_rd, r_wr, r_addr, r_wd, ($urandom_range(0, 99) < 60), 16'($urandom));
      end
    end

    // Build a state with live outputs, then reset in the middle of a burst.
    wr_reg(2'd3, 32'hC);
    wr_reg(2'd2, 32'h0001_0007);
    for (int i = 0; i < 5; i++) push(16'(16'h500 + i));
    rd_expect(2'd2, 32'h0001_0003, "control_readback");
    idle();
    check("pre_reset_irq", 32'(bus.irq), 32'd1);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'h0A0A;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_readdata", bus.readdata, 32'd0);
    check("midrst_irq", 32'(bus.irq), 32'd0);
    check("midrst_ready", 32'(bus.sample_ready), 32'd0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    rd_expect(2'd1, 32'h0000_0001, "status_after_midrst");
    rd_expect(2'd2, 32'h0000_0000, "control_after_midrst");
    repeat (3) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_fpga_fifo_write.md
Name: hps_fpga_fifo_write

Overview:
- Avalon-MM slave through which the HPS drains audio samples produced by FPGA fabric (e.g. the audio codec capture path).
- Fabric pushes fixed-width samples into an internal synchronous FIFO. The HPS pops them by reading the DATA register and polls or takes an interrupt on fill level.
- Reverse direction of the HPS-to-FPGA PIO control path; sits on the lightweight HPS-FPGA bridge beside it.

Parameters:
- DATA_W, 16, sample width in bits (1..32).
- DEPTH_LOG2, 8, FIFO depth = 2**DEPTH_LOG2 entries (256).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered, read latency 1.
- sample_data  in  DATA_W  fabric sample.
- sample_valid  in  1  fabric sample strobe, one sample per cycle high.
- sample_ready  out  1  high when capture enabled and FIFO not full.
- irq  out  1  level interrupt to HPS.

Behaviour:
- Reset: FIFO empty (rd_ptr = wr_ptr = level = 0), readdata = 0, enable = 0, irq_en = 0, threshold = 0, sticky flags = 0, irq = 0, sample_ready = 0.
- Read access: rd = chipselect & ~read_n.
- Write access: wr = chipselect & ~write_n.
- Register map:
  - 0 DATA (RO): readdata[DATA_W-1:0] = head entry, upper bits 0. A read pops one entry if not empty. A read when empty returns 0 and sets underflow; pointers are unchanged.
  - 1 STATUS (RO, no side effects): [0] empty, [1] full, [2] overflow, [3] underflow, [4] irq, [15:5] 0, [31:16] level (zero-extended, DEPTH_LOG2+1 bits significant).
  - 2 CONTROL (RW):
    - [0] enable, [1] irq_en, [31:16] threshold.
    - [2] flush: write-1 empties the FIFO in the same cycle; reads back 0.
    - Other bits read 0.
  - 3 CLEAR (WO, reads 0): write-1 to [2] clears overflow; write-1 to [3] clears underflow.
- Read latency: readdata is valid exactly 1 cycle after rd is sampled. readdata holds its value until the next read and is never wait-stated.
- Push: push = enable & sample_valid & ~full. When sample_valid & enable & full, the sample is dropped and overflow is set.
- sample_ready = enable & ~full. Samples with enable = 0 are ignored and set no flag.
- Simultaneous push and pop:
  - Level is unchanged, and both pointers advance modulo depth.
  - When full, the pop frees a slot in the same cycle, but the push is still governed by the pre-pop full flag, so the sample is dropped and overflow is set.
  - When empty, the read returns 0 with underflow set, and the push is accepted (level becomes 1).
- Flush:
  - Has priority over a same-cycle push and pop.
  - The FIFO ends empty and sticky flags are untouched.
  - A pop read in the flush cycle returns the pre-flush head.
- Level = wr_count - rd_count, range 0..2**DEPTH_LOG2. full = (level == depth), empty = (level == 0). Pointers wrap modulo depth.
- Sticky flags: a clear write in the same cycle as a new set event leaves the flag set (set wins).
- irq: registered, irq = irq_en & ((threshold != 0 & level >= threshold) | overflow). Updates one cycle after the condition changes.
- Reset mid-operation: asserting reset_n low immediately returns every state to reset values. All FIFO contents are discarded.
- Storage: inferred dual-port RAM or register array. RAM read latency must be hidden so DATA latency stays 1; use a prefetched head register if required.

Test Plan:
- Reset, then read STATUS -> 0x0000_0001 (empty, level 0); read CONTROL -> 0.
- Write CONTROL=0x1, push 0x1234, 0xABCD, 0x0007 on consecutive cycles -> STATUS level 3; three DATA reads return 0x0000_1234, 0x0000_ABCD, 0x0000_0007; STATUS -> 0x0000_0001.
- Enable, push 257 samples 0..256 with no reads -> full at 256, sample_ready low; STATUS = 0x0100_0006 (level 256, full, overflow); first DATA read returns 0.
- DATA read on empty FIFO -> readdata 0, STATUS bit3 set; write CLEAR=0x8 -> bit3 cleared.
- CONTROL=0x0004_0003 (threshold 4, irq_en, enable), push 3 samples -> irq low; 4th push -> irq high 1 cycle later; one DATA read -> irq low.
- Fill to level 10, write CONTROL with bit2 set while pushing -> level 0 next cycle, overflow unchanged. Separately, assert reset_n mid-burst -> all outputs 0 immediately.
